// File: rtl/cpu_step_ctrl_if.sv
// Run-control bundle between the debounced front panel and cpu_step_ctrl.
// Breakpoint signals exist only when BREAKPOINT_EN is defined.
interface cpu_step_ctrl_if #(
  parameter int CNT_WD = 16
`ifdef BREAKPOINT_EN
  , parameter int PC_WD = 8
`endif
) ();
  logic              step_pulse;
  logic              run_pulse;
  logic              clr_pulse;
  logic              halt_in;
  logic              cpu_en;
  logic              cpu_rst;
  logic              running;
  logic [1:0]        state;
  logic [CNT_WD-1:0] step_count;
`ifdef BREAKPOINT_EN
  logic [PC_WD-1:0]  pc;
  logic [PC_WD-1:0]  bp_addr;
  logic              bp_en;
`endif

  // master is the front-panel side; slave is the run controller
  modport master (
    output step_pulse, run_pulse, clr_pulse, halt_in,
`ifdef BREAKPOINT_EN
    output pc, bp_addr, bp_en,
`endif
    input  cpu_en, cpu_rst, running, state, step_count
  );

  modport slave (
    input  step_pulse, run_pulse, clr_pulse, halt_in,
`ifdef BREAKPOINT_EN
    input  pc, bp_addr, bp_en,
`endif
    output cpu_en, cpu_rst, running, state, step_count
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run controller producing the CPU clock-enable and reset pulse.
// Define BREAKPOINT_EN to add a pc breakpoint that stops free-run.
module cpu_step_ctrl #(
  parameter int                CNT_WD  = 16,
  parameter int                DIV_WD  = 24,
  parameter logic [DIV_WD-1:0] DIV_MAX = 24'd12499999
`ifdef BREAKPOINT_EN
  , parameter int              PC_WD   = 8
`endif
) (
  input logic             clk,
  input logic             rst_n,
  cpu_step_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STEP   = 2'b01,
    RUN    = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_WD-1:0] pre_q, pre_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              rst_q, rst_d;
  logic              run_q, run_d;
  logic              bp_hit;

`ifdef BREAKPOINT_EN
  logic [PC_WD-1:0]  pc_v;
  logic [PC_WD-1:0]  bp_v;
  assign pc_v   = bus.pc;
  assign bp_v   = bus.bp_addr;
  assign bp_hit = bus.bp_en && (pc_v == bp_v);
`else
  assign bp_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      run_q   <= run_d;
    end
  end

  // Priority: clear, then halt, then breakpoint (RUN only), then run toggle, then step
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    rst_d   = 1'b0;
    if (bus.clr_pulse) begin
      state_d = IDLE;
      rst_d   = 1'b1;
      cnt_d   = '0;
      pre_d   = '0;
    end else if (bus.halt_in) begin
      state_d = HALTED;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.run_pulse) begin
            state_d = RUN;
            pre_d   = '0;
          end else if (bus.step_pulse) begin
            state_d = STEP;
            en_d    = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        STEP: state_d = IDLE;
        RUN: begin
          if (pre_q == DIV_MAX && bp_hit) begin
            state_d = IDLE;
            pre_d   = '0;
          end else if (bus.run_pulse) begin
            state_d = IDLE;
            pre_d   = '0;
          end else if (pre_q == DIV_MAX) begin
            en_d    = 1'b1;
            pre_d   = '0;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            pre_d   = pre_q + 1'b1;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
    run_d = (state_d == RUN);
  end

  assign bus.cpu_en     = en_q;
  assign bus.cpu_rst    = rst_q;
  assign bus.running    = run_q;
  assign bus.state      = state_q;
  assign bus.step_count = cnt_q;

endmodule
